cmos_capture_data: RTL and testbench
====================================

// Module: cmos_capture_data
// PURPOSE
//  Camera-side capture stage between the OV5640 DVP pins and the DDR3 write port of ddr3_ctrl_top.
//  - Holds off output for WAIT_FRAME frames after capture_start so camera register settings settle.
//  - Packs the 8-bit byte stream into 16-bit RGB565 words.
//  - Regenerates frame vsync/href/valid for the frame buffer.
//  - Checks every line and frame against the programmed resolution.
// PARAMETERS
//  WAIT_FRAME  10  frames discarded after capture_start before output is enabled (1..255)
// PORTS
//  clk               in   1   cam_pclk domain clock, all logic on rising edge
//  rst               in   1   synchronous reset, active-high
//  capture_start     in   1   level; 1 = DDR3 init done, frame counting allowed
//  cmos_h_pixel      in   13  expected 16-bit words per line
//  cmos_v_pixel      in   13  expected lines per frame
//  cam_vsync         in   1   camera vsync; high between frames
//  cam_href          in   1   camera line-valid
//  cam_data          in   8   camera byte; first byte = RGB565[15:8], second byte = [7:0]
//  cmos_frame_vsync  out  1   delayed cam_vsync, gated by enable (drives DDR wr_load)
//  cmos_frame_href   out  1   delayed cam_href, gated by enable
//  cmos_frame_valid  out  1   1-cycle strobe per packed pixel (drives wd_en)
//  cmos_frame_data   out  16  packed RGB565 pixel, valid with cmos_frame_valid
//  frame_en          out  1   1 = WAIT_FRAME reached, outputs live
//  line_err          out  1   sticky per frame: a line had wrong word count or an odd byte count
//  frame_err         out  1   1-cycle pulse at frame end when the line count != cmos_v_pixel
// BEHAVIOUR
//  Reset
//   - All outputs and internal registers go to 0 on rst.
//   - Reset mid-frame drops the partial word and restarts the WAIT_FRAME count.
//  Input sampling
//   - cam_vsync, cam_href and cam_data are registered into d0, then vsync and href into d1.
//   - vs_pos = vsync_d0 & ~vsync_d1; hr_neg = ~href_d0 & href_d1.
//  Frame gate
//   - capture_start=0: wait_cnt (8b) and frame_en are held at 0.
//   - Otherwise each vs_pos increments wait_cnt, saturating at WAIT_FRAME.
//   - frame_en rises on the cycle after wait_cnt reaches WAIT_FRAME.
//   - frame_en stays 1 until rst or capture_start=0. Enabling therefore always starts at a vsync boundary.
//  Byte packing (only while href_d0=1 and vsync_d0=0)
//   - byte_flag toggles every cycle and is cleared whenever href_d0=0.
//   - byte_flag=0: cam_data_d0 is stored as the high byte.
//   - byte_flag=1: cmos_frame_data <= {hi, cam_data_d0} and valid_int <= 1.
//   - href while vsync_d0=1 is ignored: no packing, no valid.
//  Outputs
//   - cmos_frame_vsync = vsync_d1 & frame_en.
//   - cmos_frame_href = href_d1 & frame_en.
//   - cmos_frame_valid = valid_int & frame_en.
//   - cmos_frame_data is 0 when frame_en=0.
//  Latency
//   - A second byte present at edge t gives valid/data high after edge t+2 (2 cycles).
//   - valid strobes are never back-to-back; at least 1 idle cycle lies between them.
//  Checking
//   - h_cnt (13b) counts valid_int per line; it clears on hr_neg, after the compare.
//   - v_cnt (13b) increments on hr_neg and clears on vs_pos, after the compare.
//   - Line check, on hr_neg: if h_cnt != cmos_h_pixel, or byte_flag=1 (odd byte count), set line_err.
//     The odd partial byte is discarded.
//   - Frame check, on vs_pos with frame_en=1: frame_err pulses if v_cnt != cmos_v_pixel.
//     The first vs_pos after reset never flags.
//   - line_err clears on vs_pos.
//   - Counters saturate at 8191; no wrap.
//   - Checks run regardless of frame_en. The error outputs are only meaningful when frame_en=1.
//  Simultaneous events
//   - vs_pos and hr_neg in the same cycle: the line check is done first, then v_cnt clears (v_cnt ends at 0).
// TESTING
//  1. WAIT_FRAME=3, capture_start=1, 5 frames of 4x2 words
//     -> valid stays 0 for frames 1-3; frames 4-5 each give exactly 8 valid strobes; no errors.
//  2. Byte stream 0x12,0x34,0x56,0x78 on one href
//     -> data 0x1234 then 0x5678, each 2 cycles after its second byte; idle cycle between strobes.
//  3. cmos_h_pixel=4, a line of 7 bytes
//     -> 3 strobes; line_err=1 until the next vs_pos, then 0.
//  4. cmos_v_pixel=2, a frame with 3 lines after enable
//     -> frame_err 1-cycle pulse on the next vs_pos; no pulse for a 2-line frame.
//  5. rst asserted mid-line after enable
//     -> all outputs 0 the next cycle; WAIT_FRAME full frames required before valid returns.
//  6. capture_start dropped mid-frame
//     -> frame_en=0 next cycle; vsync/href/valid outputs forced 0; wait_cnt restarts from 0.

Source files
------------

// File: rtl/cmos_capture_data.sv
// OV5640 DVP capture: holds off output for WAIT_FRAME frames, packs byte pairs into RGB565
// words, regenerates frame timing for the frame buffer and checks line/frame geometry.
module cmos_capture_data #(
  parameter int WAIT_FRAME = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_start,
  input  logic [12:0] cmos_h_pixel,
  input  logic [12:0] cmos_v_pixel,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        cmos_frame_vsync,
  output logic        cmos_frame_href,
  output logic        cmos_frame_valid,
  output logic [15:0] cmos_frame_data,
  output logic        frame_en,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [7:0]  WAIT_CNT = 8'(WAIT_FRAME);
  localparam logic [12:0] CNT_MAX  = 13'h1fff;

  logic        r_vsync_d0, r_vsync_d1;
  logic        r_href_d0, r_href_d1;
  logic [7:0]  r_data_d0;
  logic [7:0]  r_wait_cnt;
  logic        r_frame_en;
  logic        r_byte_flag;
  logic [7:0]  r_hi_byte;
  logic [15:0] r_pix_data;
  logic        r_valid;
  logic [12:0] r_h_cnt;
  logic [12:0] r_v_cnt;
  logic        r_line_err;
  logic        r_frame_err;

  logic        w_vs_pos;
  logic        w_hr_neg;
  logic        w_pack_en;
  logic [12:0] w_h_total;
  logic        w_line_bad;

  assign w_vs_pos  = r_vsync_d0 & ~r_vsync_d1;
  assign w_hr_neg  = ~r_href_d0 & r_href_d1;
  assign w_pack_en = r_href_d0 & ~r_vsync_d0;

  // The last word of a line is still in r_valid when hr_neg fires, so fold it into the compare.
  always_comb begin
    w_h_total = r_h_cnt;
    if (r_valid && (r_h_cnt != CNT_MAX)) begin
      w_h_total = r_h_cnt + 13'd1;
    end
    w_line_bad = (w_h_total != cmos_h_pixel) || r_byte_flag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d0 <= 1'b0;
      r_vsync_d1 <= 1'b0;
      r_href_d0  <= 1'b0;
      r_href_d1  <= 1'b0;
      r_data_d0  <= 8'd0;
    end else begin
      r_vsync_d0 <= cam_vsync;
      r_vsync_d1 <= r_vsync_d0;
      r_href_d0  <= cam_href;
      r_href_d1  <= r_href_d0;
      r_data_d0  <= cam_data;
    end
  end

  // Enable only ever rises during vsync, so the first live frame is always whole.
  always_ff @(posedge clk) begin
    if (rst || !capture_start) begin
      r_wait_cnt <= 8'd0;
      r_frame_en <= 1'b0;
    end else begin
      if (w_vs_pos && (r_wait_cnt < WAIT_CNT)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if (r_wait_cnt == WAIT_CNT) begin
        r_frame_en <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_flag <= 1'b0;
      r_hi_byte   <= 8'd0;
      r_pix_data  <= 16'd0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_pack_en) begin
        r_byte_flag <= ~r_byte_flag;
        if (!r_byte_flag) begin
          r_hi_byte <= r_data_d0;
        end else begin
          r_pix_data <= {r_hi_byte, r_data_d0};
          r_valid    <= 1'b1;
        end
      end else begin
        r_byte_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= 13'd0;
    end else if (w_hr_neg) begin
      r_h_cnt <= 13'd0;
    end else if (r_valid && (r_h_cnt != CNT_MAX)) begin
      r_h_cnt <= r_h_cnt + 13'd1;
    end
  end

  // vs_pos clears after any coincident line check, so a line ending on vs_pos leaves v_cnt at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_cnt     <= 13'd0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_vs_pos && r_frame_en && (r_v_cnt != cmos_v_pixel);
      if (w_vs_pos) begin
        r_v_cnt    <= 13'd0;
        r_line_err <= 1'b0;
      end else if (w_hr_neg) begin
        if (r_v_cnt != CNT_MAX) begin
          r_v_cnt <= r_v_cnt + 13'd1;
        end
        if (w_line_bad) begin
          r_line_err <= 1'b1;
        end
      end
    end
  end

  assign cmos_frame_vsync = r_vsync_d1 & r_frame_en;
  assign cmos_frame_href  = r_href_d1 & r_frame_en;
  assign cmos_frame_valid = r_valid & r_frame_en;
  assign cmos_frame_data  = r_frame_en ? r_pix_data : 16'd0;
  assign frame_en         = r_frame_en;
  assign line_err         = r_line_err;
  assign frame_err        = r_frame_err;

endmodule

// File: tb/tb_cmos_capture_data.sv
// Randomised bench for cmos_capture_data: a frame-level model predicts pixels, their arrival
// cycle, enable state and line/frame error flags; a negedge monitor checks the pixel stream.
module tb_cmos_capture_data;

  localparam int WAIT_FRAME = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_start;
  logic [12:0] cmos_h_pixel;
  logic [12:0] cmos_v_pixel;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        cmos_frame_vsync;
  logic        cmos_frame_href;
  logic        cmos_frame_valid;
  logic [15:0] cmos_frame_data;
  logic        frame_en;
  logic        line_err;
  logic        frame_err;

  cmos_capture_data #(.WAIT_FRAME(WAIT_FRAME)) dut (
    .clk              (clk),
    .rst              (rst),
    .capture_start    (capture_start),
    .cmos_h_pixel     (cmos_h_pixel),
    .cmos_v_pixel     (cmos_v_pixel),
    .cam_vsync        (cam_vsync),
    .cam_href         (cam_href),
    .cam_data         (cam_data),
    .cmos_frame_vsync (cmos_frame_vsync),
    .cmos_frame_href  (cmos_frame_href),
    .cmos_frame_valid (cmos_frame_valid),
    .cmos_frame_data  (cmos_frame_data),
    .frame_en         (frame_en),
    .line_err         (line_err),
    .frame_err        (frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          ferr_seen = 0;
  logic        prev_valid = 1'b0;

  // Frame-level model of the camera path.
  int m_wait;
  bit m_en;
  bit m_cap;
  int m_lines;
  bit m_err;
  int h_pix;
  int v_pix;

  logic [7:0] lb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_seen++;
    if (cmos_frame_valid === 1'b1) begin
      check("valid_spacing", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got data %0h expected no strobe (cycle %0d)",
                 cmos_frame_data, cyc);
      end else begin
        check("pix_data", {16'd0, cmos_frame_data}, {16'd0, exp_q.pop_front()});
        check("pix_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    prev_valid = (cmos_frame_valid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk);
    #1;
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic fill_rand(input int n);
    lb.delete();
    repeat (n) lb.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic model_reset();
    m_wait  = 0;
    m_en    = 1'b0;
    m_lines = 0;
    m_err   = 1'b0;
  endtask

  task automatic send_line(input int nbytes);
    logic [7:0] hi;
    hi = 8'd0;
    for (int i = 0; i < nbytes; i++) begin
      drive(1'b0, 1'b1, lb[i]);
      if (i % 2 == 0) begin
        hi = lb[i];
      end else if (m_en) begin
        exp_q.push_back({hi, lb[i]});
        exp_cyc_q.push_back(cyc + 2);
      end
      if (i == 3) begin
        @(negedge clk);
        check("href_out", {31'd0, cmos_frame_href}, {31'd0, m_en});
      end
    end
    if ((nbytes % 2 != 0) || (nbytes / 2 != h_pix)) m_err = 1'b1;
    m_lines++;
    idle(4);
    @(negedge clk);
    check("line_err", {31'd0, line_err}, {31'd0, m_err});
  endtask

  task automatic send_vsync();
    bit exp_pulse;
    int f0;
    exp_pulse = m_en && (m_lines != v_pix);
    f0 = ferr_seen;
    if (m_cap) begin
      if (m_wait < WAIT_FRAME) m_wait++;
      m_en = (m_wait == WAIT_FRAME);
    end
    m_lines = 0;
    m_err   = 1'b0;
    repeat (5) drive(1'b1, 1'b0, 8'd0);
    @(negedge clk);
    check("frame_en", {31'd0, frame_en}, {31'd0, m_en});
    check("vsync_out", {31'd0, cmos_frame_vsync}, {31'd0, m_en});
    idle(5);
    @(negedge clk);
    check("frame_err_pulses", ferr_seen - f0, {31'd0, exp_pulse});
    check("line_err_clear", {31'd0, line_err}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_en"}, {31'd0, frame_en}, 32'd0);
    check({tag, "_vsync"}, {31'd0, cmos_frame_vsync}, 32'd0);
    check({tag, "_href"}, {31'd0, cmos_frame_href}, 32'd0);
    check({tag, "_valid"}, {31'd0, cmos_frame_valid}, 32'd0);
    check({tag, "_data"}, {16'd0, cmos_frame_data}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lens[6];
    lens = '{6, 7, 8, 8, 8, 9};
    rst = 1'b1;
    capture_start = 1'b0;
    h_pix = 4;
    v_pix = 2;
    cmos_h_pixel = 13'd4;
    cmos_v_pixel = 13'd2;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'd0;
    m_cap = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_line_err", {31'd0, line_err}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    #1 rst = 1'b0;
    capture_start = 1'b1;
    m_cap = 1'b1;

    // Five frames of 4x2 words: only the last two reach the output.
    for (int f = 0; f < 5; f++) begin
      for (int l = 0; l < 2; l++) begin
        fill_rand(8);
        send_line(8);
      end
      send_vsync();
    end

    // Directed byte order and latency.
    lb.delete();
    lb.push_back(8'h12); lb.push_back(8'h34); lb.push_back(8'h56); lb.push_back(8'h78);
    send_line(4);
    fill_rand(8);
    send_line(8);
    send_vsync();

    // Odd-length line.
    fill_rand(7);
    send_line(7);
    fill_rand(8);
    send_line(8);
    send_vsync();

    // Three-line frame flags, two-line frame does not.
    repeat (3) begin fill_rand(8); send_line(8); end
    send_vsync();
    repeat (2) begin fill_rand(8); send_line(8); end
    send_vsync();

    // Random geometry.
    repeat (6) begin
      int nl;
      nl = $urandom_range(1, 3);
      repeat (nl) begin
        int nb;
        nb = lens[$urandom_range(0, 5)];
        fill_rand(nb);
        send_line(nb);
      end
      send_vsync();
    end

    // Reset in the middle of a line.
    fill_rand(8);
    send_line(8);
    drive(1'b0, 1'b1, 8'hab);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cam_href = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midline_rst");
    #1 rst = 1'b0;
    model_reset();
    for (int f = 0; f < 5; f++) begin
      repeat (2) begin fill_rand(8); send_line(8); end
      send_vsync();
    end

    // capture_start dropped between lines of a live frame.
    fill_rand(8);
    send_line(8);
    @(posedge clk);
    #1;
    capture_start = 1'b0;
    m_cap = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("cap_drop");
    fill_rand(8);
    send_line(8);
    send_vsync();
    @(posedge clk);
    #1;
    capture_start = 1'b1;
    m_cap = 1'b1;
    for (int f = 0; f < 5; f++) begin
      repeat (2) begin fill_rand(8); send_line(8); end
      send_vsync();
    end

    idle(10);
    check("pending_pixels", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
